// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one result bit per cycle.
module muldiv_iter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] data_1,
  input  logic [N-1:0] data_2,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out
);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned W2 = 2 * N;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic          s1_q, s1_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  data_out_q, data_out_d;

  // Operand sign handling at accept
  logic         signed_1, signed_2, s1_in, s2_in;
  logic [N-1:0] abs_1, abs_2;
  logic         div_zero, div_ovf;
  logic [N-1:0] special_res;

  assign signed_1 = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
  assign signed_2 = (op == 3'b001) || (op[2] && !op[0]);
  assign s1_in    = signed_1 & data_1[N-1];
  assign s2_in    = signed_2 & data_2[N-1];
  assign abs_1    = s1_in ? (~data_1 + N'(1)) : data_1;
  assign abs_2    = s2_in ? (~data_2 + N'(1)) : data_2;
  assign div_zero = op[2] && (data_2 == '0);
  assign div_ovf  = op[2] && !op[0] && (data_1 == MIN_NEG) && (&data_2);
  assign special_res = div_zero ? (op[1] ? data_1 : '1) : (op[1] ? '0 : data_1);

  // One iteration of each datapath, plus the final sign fix-up
  logic [N:0]    mul_sum, rem_shift, rem_diff;
  logic [W2-1:0] mul_step, prod;
  logic [N-1:0]  rem_step, quot_step, quot_fix, rem_fix, res_final;

  assign mul_sum   = {1'b0, acc_q[W2-1:N]} + {1'b0, opnd_q & {N{acc_q[0]}}};
  assign mul_step  = {mul_sum, acc_q[N-1:1]};
  assign prod      = neg_q ? (~mul_step + W2'(1)) : mul_step;
  assign rem_shift = {rem_q, acc_q[N-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  assign rem_step  = rem_diff[N] ? rem_shift[N-1:0] : rem_diff[N-1:0];
  assign quot_step = {acc_q[N-2:0], ~rem_diff[N]};
  assign quot_fix  = neg_q ? (~quot_step + N'(1)) : quot_step;
  assign rem_fix   = s1_q ? (~rem_step + N'(1)) : rem_step;
  assign res_final = op_q[2] ? (op_q[1] ? rem_fix : quot_fix)
                             : ((op_q == 3'b000) ? prod[N-1:0] : prod[W2-1:N]);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    s1_d        = s1_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d  = op;
          neg_d = s1_in ^ s2_in;
          s1_d  = s1_in;
          cnt_d = '0;
          rem_d = '0;
          // Multiply: opnd = multiplicand, acc low = multiplier; divide: opnd = divisor
          opnd_d = op[2] ? abs_2 : abs_1;
          acc_d  = {{N{1'b0}}, (op[2] ? abs_1 : abs_2)};
          if (div_zero || div_ovf) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            data_out_d  = special_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[2]) begin
          acc_d = {acc_q[W2-1:N], quot_step};
          rem_d = rem_step;
        end else begin
          acc_d = mul_step;
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          data_out_d  = res_final;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      data_out_d  = data_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      s1_q        <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      s1_q        <= s1_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed test-plan cases plus random ops against
// an arithmetic reference model.
module tb_muldiv_iter;
  localparam int unsigned N   = 32;
  localparam int          LAT = N + 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]   op;
  logic [N-1:0] data_1, data_2, data_out;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data_1(data_1), .data_2(data_2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics computed with wide arithmetic
  function automatic logic [N-1:0] ref_model(input logic [2:0] f, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    logic [2*N-1:0] xa, xb, p;
    logic [N-1:0]   r;
    logic           ovf;
    xa  = (f == 3'b001 || f == 3'b010) ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    xb  = (f == 3'b001) ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    p   = xa * xb;
    ovf = (a == MIN_NEG) && (b == '1);
    case (f)
      3'b000:  r = p[N-1:0];
      3'b100:  r = (b == '0) ? '1 : (ovf ? a : N'($signed(a) / $signed(b)));
      3'b101:  r = (b == '0) ? '1 : a / b;
      3'b110:  r = (b == '0) ? a : (ovf ? '0 : N'($signed(a) % $signed(b)));
      3'b111:  r = (b == '0) ? a : a % b;
      default: r = p[2*N-1:N];
    endcase
    return r;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 3 * N) begin
      step();
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                       input string tag);
    int lat, exp_lat;
    logic [N-1:0] exp;
    exp     = ref_model(f, a, b);
    exp_lat = (f[2] && (b == '0 || (!f[0] && a == MIN_NEG && b == '1))) ? 1 : LAT;
    chk(64'(in_ready), 64'(1), {tag, "_ready"});
    op = f; data_1 = a; data_2 = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    chk(64'(lat), 64'(exp_lat), {tag, "_lat"});
    chk(64'(data_out), 64'(exp), {tag, "_data"});
    step();
    chk(64'(out_valid), 64'(0), {tag, "_ovdrop"});
    chk(64'(in_ready), 64'(1), {tag, "_idle"});
  endtask

  initial begin
    int lat, seen;
    logic [N-1:0] prev, a, b;
    logic [2:0] f;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; data_1 = '0; data_2 = '0;
    repeat (3) step();
    chk(64'(in_ready), 64'(1), "rst_ready");
    chk(64'(out_valid), 64'(0), "rst_valid");
    chk(64'(data_out), 64'(0), "rst_data");
    rst_n = 1'b1;
    step();

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul");
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'b000, 32'h0001_0000, 32'h0001_0000, "mul_wrap");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem");
    do_op(3'b101, 32'd7, 32'd2, "divu");
    do_op(3'b111, 32'd7, 32'd2, "remu");
    do_op(3'b100, 32'd5, 32'd0, "div0");
    do_op(3'b111, 32'd5, 32'd0, "remu0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

    // Backpressure with a second request pending
    op = 3'b000; data_1 = 32'd123; data_2 = 32'd456; in_valid = 1'b1; out_ready = 1'b0;
    step();
    op = 3'b101; data_1 = 32'd100; data_2 = 32'd7;
    wait_valid(lat);
    chk(64'(lat), 64'(LAT), "bp_lat");
    chk(64'(data_out), 64'(56088), "bp_data");
    for (int i = 0; i < 5; i++) begin
      step();
      chk(64'(out_valid), 64'(1), "bp_hold_valid");
      chk(64'(data_out), 64'(56088), "bp_hold_data");
      chk(64'(in_ready), 64'(0), "bp_hold_ready");
    end
    out_ready = 1'b1;
    step();
    chk(64'(out_valid), 64'(0), "bp_xfer_valid");
    chk(64'(in_ready), 64'(1), "bp_xfer_ready");
    step();
    in_valid = 1'b0;
    chk(64'(in_ready), 64'(0), "bp_second_acc");
    wait_valid(lat);
    chk(64'(lat), 64'(LAT), "bp2_lat");
    chk(64'(data_out), 64'(14), "bp2_data");
    step();

    // Flush in CALC cycle 10
    prev = data_out;
    op = 3'b011; data_1 = 32'hDEAD_BEEF; data_2 = 32'h1234_5678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk(64'(in_ready), 64'(1), "fl_ready");
    chk(64'(out_valid), 64'(0), "fl_valid");
    chk(64'(data_out), 64'(prev), "fl_data_kept");
    seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk(64'(seen), 64'(0), "fl_no_pulse");

    // Reset in CALC cycle 10
    op = 3'b100; data_1 = 32'd1000; data_2 = 32'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk(64'(in_ready), 64'(1), "rs_ready");
    chk(64'(out_valid), 64'(0), "rs_valid");
    chk(64'(data_out), 64'(0), "rs_data");
    seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk(64'(seen), 64'(0), "rs_no_pulse");

    // Flush wins over accept in IDLE
    op = 3'b100; data_1 = 32'd9; data_2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk(64'(in_ready), 64'(1), "flacc_ready");
    chk(64'(out_valid), 64'(0), "flacc_valid");
    step();
    chk(64'(out_valid), 64'(0), "flacc_valid2");

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = MIN_NEG; b = '1; end
        2: b = N'($urandom_range(1, 15));
        3: a = N'($urandom_range(0, 15));
        4: b = ~N'($urandom_range(0, 3));
        default: ;
      endcase
      do_op(f, a, b, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Multi-cycle, parametrised RISC-V M-extension unit: iterative multiply (MUL/MULH/MULHSU/MULHU) and divide/remainder (DIV/DIVU/REM/REMU) over N-bit operands. It sits beside the single-cycle ALU in the execute stage. It removes the wide combinational multiplier and divider from the critical path, at the cost of N+1 cycles of latency per operation. It adds a valid/ready handshake, flush, and architecturally defined divide-by-zero and overflow results.

## Interface
- N, 32: operand/result width; N ≥ 4, even.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit idle and able to accept a request; equals (state == IDLE).
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data_1  in  N  rs1 operand (dividend / multiplicand).
- data_2  in  N  rs2 operand (divisor / multiplier).
- flush  in  1  synchronous abort of any in-flight or pending operation.
- out_valid  out  1  data_out holds a result.
- out_ready  in  1  consumer accepts the result.
- data_out  out  N  result, registered.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on accept (in_valid & in_ready & !flush) for normal ops.
  - IDLE→DONE on accept of a special-case divide.
  - CALC→DONE after exactly N CALC cycles.
  - DONE→IDLE when out_ready.
  - Any state→IDLE on flush or !rst_n.
- Accept: latch op and operand signs. Latch |data_1| and |data_2| for signed operands, raw values for unsigned operands.
  - MULH: both operands signed.
  - MULHSU: data_1 signed, data_2 unsigned.
  - MULHU: both unsigned.
  - MUL: treated as unsigned; the low N bits are sign-independent.
  - DIV/REM: both signed. DIVU/REMU: both unsigned.
- Multiply: radix-2 shift-add, one multiplier bit per CALC cycle, into a 2N-bit accumulator.
  - Result negated (two's complement, 2N bits) if the operand signs differ.
  - MUL returns bits [N-1:0]; MULH/MULHSU/MULHU return bits [2N-1:N].
- Divide: restoring radix-2, one quotient bit per CALC cycle, with an N+1-bit partial remainder.
  - Quotient negated if the signs differ. Remainder takes the sign of the dividend.
- Sign fix-up happens on the CALC→DONE edge, so no extra cycle is added.
- Special cases, detected at accept, skip CALC:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → data_1.
  - Signed overflow, DIV with data_1 = 1 followed by N-1 zeros and data_2 = all ones: DIV → data_1; REM → 0.
- data_out and out_valid are registered. data_out is held stable while out_valid & !out_ready.
- No new request is accepted in the DONE cycle; in_ready is low until the state returns to IDLE.
- Flush has priority over accept in the same cycle.
  - No result is produced for the flushed operation.
  - out_valid goes low on the flush edge.
  - data_out keeps its last value.
- Reset values: state IDLE, out_valid 0, data_out 0, iteration counter 0, internal accumulators 0. in_ready is 1 once state is IDLE.

## Timing
- Accept edge is t0.
- Normal ops: CALC occupies cycles t0+1 … t0+N. out_valid is high from t0+N+1 (N+1 cycles latency).
- Special-case divides: out_valid is high from t0+1 (1 cycle latency).
- Result transfer happens on the edge where out_valid & out_ready. in_ready rises the cycle after.
- Minimum issue interval: N+2 cycles for normal ops, 2 cycles for special cases (with out_ready held high).
- Iteration counter: width ⌈log2 N⌉+1. It never wraps inside an operation and is cleared on accept.
- rst_n low mid-operation: IDLE, out_valid 0, data_out 0 after that edge. No stale result appears after reset release.
- in_valid while !in_ready: ignored. The requester must hold op/data until accepted.

## Test plan
- N=32, MUL 7 × 0xFFFFFFFD → data_out 0xFFFFFFEB, out_valid exactly 33 cycles after accept. MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE. MUL 0x10000 × 0x10000 → 0x00000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. DIVU 7/2 → 3; REMU 7/2 → 1. All with latency 33.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0. Each with out_valid 1 cycle after accept, never entering CALC.
- Backpressure: hold out_ready low 5 cycles after out_valid → data_out stable, in_ready 0, second in_valid not accepted. Raise out_ready → transfer, in_ready 1 next cycle, then second op accepted.
- Flush at CALC cycle 10, and separately rst_n low at CALC cycle 10 → IDLE and in_ready 1 after the edge, no out_valid pulse for that op. Flush asserted together with in_valid in IDLE → request not accepted.
